// File: rtl/fir_feeder.sv
// fir_feeder: host-side loader for the fir filter block.
//   Buffers NUM_TAPS coefficients and streams them to the filter as one
//   unbroken coef_enable burst. Afterwards it issues host samples, one per
//   cycle, from a small FIFO. It watches the filter's error flag.
// Optional feature macro: FIR_FEEDER_RETRY_EN. When it is defined, a filter
//   error triggers up to MAX_RETRY automatic reload bursts.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   cfg_we/addr/data  coefficient buffer write (ignored while loading)
//   load_start     request to stream the coefficient buffer
//   s_valid/s_data/s_ready  host sample push interface
//   data_in, coef_enable, sample_enable  filter loading protocol (registered)
//   fir_error      error flag from the filter
//   busy           burst in progress
//   loaded         a full burst completed with no error since
//   err            sticky filter-error flag
module fir_feeder #(
  parameter int NUM_TAPS   = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_TAPS)-1:0] cfg_addr,
  input  logic [DATA_W-1:0]           cfg_data,
  input  logic                        load_start,
  input  logic                        s_valid,
  input  logic [DATA_W-1:0]           s_data,
  output logic                        s_ready,
  output logic [DATA_W-1:0]           data_in,
  output logic                        coef_enable,
  output logic                        sample_enable,
  input  logic                        fir_error,
  output logic                        busy,
  output logic                        loaded,
  output logic                        err
);

  localparam int CW  = $clog2(NUM_TAPS);
  localparam int TCW = $clog2(NUM_TAPS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]     TAPS_ADDR = (CW + 1)'(NUM_TAPS);
  localparam logic [TCW-1:0]  TAPS_CNT  = TCW'(NUM_TAPS);
  localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERROR} state_t;

  state_t            r_state;
  logic [TCW-1:0]    r_tap;
  logic [DATA_W-1:0] r_coef [NUM_TAPS];
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_s_ready;
  logic [DATA_W-1:0] r_data;
  logic              r_coef_en;
  logic              r_samp_en;
  logic              r_busy;
  logic              r_loaded;
  logic              r_err;

  logic              w_cfg_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_err_enter;
  logic              w_burst_done;
  logic              w_auto_retry;
  logic              w_start;
  logic [AW:0]       w_count_next;

  assign s_ready       = r_s_ready;
  assign data_in       = r_data;
  assign coef_enable   = r_coef_en;
  assign sample_enable = r_samp_en;
  assign busy          = r_busy;
  assign loaded        = r_loaded;
  assign err           = r_err;

  // Writes are blocked during a burst so the streamed contents stay coherent.
  assign w_cfg_wr     = cfg_we && (r_state != S_LOAD) && ({1'b0, cfg_addr} < TAPS_ADDR);
  assign w_push       = s_valid && r_s_ready;
  assign w_err_enter  = ((r_state == S_LOAD) || (r_state == S_RUN)) && fir_error;
  // r_tap == NUM_TAPS means the last coefficient is on data_in this cycle.
  assign w_burst_done = (r_state == S_LOAD) && (r_tap == TAPS_CNT) && !fir_error;
  assign w_start      = w_auto_retry || (load_start && (r_state != S_LOAD) && !w_err_enter);
  // Pop decisions use the registered count only, so a sample pushed this
  // cycle can issue no earlier than the next one.
  assign w_pop        = (r_count != '0) &&
                        (w_burst_done || ((r_state == S_RUN) && !fir_error && !load_start));
  assign w_count_next = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

`ifdef FIR_FEEDER_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] r_retry;

  // ERROR lasts one cycle when a retry is still available.
  assign w_auto_retry = (r_state == S_ERROR) && (r_retry < RETRY_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_retry <= '0;
    end else if (w_burst_done) begin
      r_retry <= '0;
    end else if (w_auto_retry) begin
      r_retry <= r_retry + RW'(1);
    end
  end
`else
  assign w_auto_retry = 1'b0;
`endif

  // Storage arrays carry no reset; the coefficient buffer survives reset.
  always_ff @(posedge clk) begin
    if (w_cfg_wr) begin
      r_coef[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tap     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_s_ready <= 1'b0;
      r_data    <= '0;
      r_coef_en <= 1'b0;
      r_samp_en <= 1'b0;
      r_busy    <= 1'b0;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_s_ready <= (w_count_next != FIFO_FULL);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      r_coef_en <= 1'b0;
      r_samp_en <= 1'b0;
      // A pop never coincides with a burst start or an error entry, so the
      // data_in writes below cannot collide with this one.
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_data    <= r_fifo[r_rd_ptr];
        r_samp_en <= 1'b1;
      end

      if (w_err_enter) begin
        r_state  <= S_ERROR;
        r_err    <= 1'b1;
        r_loaded <= 1'b0;
        r_busy   <= 1'b0;
        r_tap    <= '0;
      end else if (w_start) begin
        r_state   <= S_LOAD;
        r_busy    <= 1'b1;
        r_loaded  <= 1'b0;
        r_coef_en <= 1'b1;
        r_data    <= r_coef[0];
        r_tap     <= TCW'(1);
      end else if (r_state == S_LOAD) begin
        if (r_tap == TAPS_CNT) begin
          r_state  <= S_RUN;
          r_busy   <= 1'b0;
          r_loaded <= 1'b1;
          r_tap    <= '0;
        end else begin
          r_coef_en <= 1'b1;
          r_data    <= r_coef[r_tap[CW-1:0]];
          r_tap     <= r_tap + TCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: self-checking bench for fir_feeder (default parameters).
//   Expected coefficients and samples are queued when stimulus is driven and
//   popped whenever the DUT raises coef_enable / sample_enable.
module tb_fir_feeder;
  localparam int NUM_TAPS   = 5;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_RETRY  = 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        cfg_we = 1'b0;
  logic [$clog2(NUM_TAPS)-1:0] cfg_addr = '0;
  logic [DATA_W-1:0]           cfg_data = '0;
  logic                        load_start = 1'b0;
  logic                        s_valid = 1'b0;
  logic [DATA_W-1:0]           s_data = '0;
  logic                        s_ready;
  logic [DATA_W-1:0]           data_in;
  logic                        coef_enable;
  logic                        sample_enable;
  logic                        fir_error = 1'b0;
  logic                        busy;
  logic                        loaded;
  logic                        err;

  always #5 clk = ~clk;

  fir_feeder #(
    .NUM_TAPS(NUM_TAPS), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .load_start(load_start), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .data_in(data_in), .coef_enable(coef_enable), .sample_enable(sample_enable),
    .fir_error(fir_error), .busy(busy), .loaded(loaded), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_coef_q[$];
  logic [DATA_W-1:0] exp_samp_q[$];
  logic [DATA_W-1:0] exp_v;
  logic [DATA_W-1:0] coef_tab [NUM_TAPS] = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_coefs(input int n);
    for (int i = 0; i < n; i++) exp_coef_q.push_back(coef_tab[i]);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({coef_enable, sample_enable, busy, loaded, err, s_ready} !== 6'b0 || data_in !== '0)
      $display("FAIL reset_outputs: got ce=%b se=%b busy=%b loaded=%b err=%b rdy=%b data=%0d, expected all 0",
               coef_enable, sample_enable, busy, loaded, err, s_ready, data_in);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", s_ready);
    else n_pass++;
  endtask

  task automatic test_coef_burst;
    for (int i = 0; i < NUM_TAPS; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = coef_tab[i];
      tick();
    end
    cfg_we = 1'b0;
    load_start = 1'b1;
    push_coefs(NUM_TAPS);
    tick();
    load_start = 1'b0;
    for (int c = 0; c < NUM_TAPS + 2; c++) begin
      n_checks++;
      if (coef_enable !== (c < NUM_TAPS) || busy !== (c < NUM_TAPS) || sample_enable !== 1'b0)
        $display("FAIL burst_enables c=%0d: got ce=%b busy=%b se=%b expected ce=busy=%b se=0",
                 c, coef_enable, busy, sample_enable, (c < NUM_TAPS));
      else n_pass++;
      if (coef_enable === 1'b1) begin
        n_checks++;
        if (exp_coef_q.size() == 0) $display("FAIL burst_extra_coef: got %0d expected none", data_in);
        else begin
          exp_v = exp_coef_q.pop_front();
          if (data_in !== exp_v) $display("FAIL burst_coef: got %0d expected %0d", data_in, exp_v);
          else n_pass++;
        end
        $display("coef %0d", data_in);
      end
      // This write lands during the burst and must be dropped.
      cfg_we = (c == 1); cfg_addr = '0; cfg_data = 8'd99;
      tick();
    end
    cfg_we = 1'b0;
    n_checks++;
    if (loaded !== 1'b1 || busy !== 1'b0 || exp_coef_q.size() != 0)
      $display("FAIL burst_end: got loaded=%b busy=%b left=%0d expected 1 0 0", loaded, busy, exp_coef_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int first, last, nseen;
    logic [DATA_W-1:0] stim [3] = '{8'd10, 8'd20, 8'd30};
    first = -1; last = -1; nseen = 0;
    for (int c = 0; c < 8; c++) begin
      s_valid = (c < 3);
      s_data  = (c < 3) ? stim[c] : 8'd0;
      if (s_valid && s_ready) exp_samp_q.push_back(s_data);
      tick();
      n_checks++;
      if (s_ready !== 1'b1) $display("FAIL b2b_ready c=%0d: got %b expected 1", c, s_ready);
      else n_pass++;
      if (sample_enable === 1'b1) begin
        if (first < 0) first = c;
        last = c; nseen++;
        n_checks++;
        if (exp_samp_q.size() == 0) $display("FAIL b2b_extra_sample: got %0d expected none", data_in);
        else begin
          exp_v = exp_samp_q.pop_front();
          if (data_in !== exp_v || coef_enable !== 1'b0)
            $display("FAIL b2b_sample: got %0d ce=%b expected %0d ce=0", data_in, coef_enable, exp_v);
          else n_pass++;
        end
        $display("sample %0d", data_in);
      end
    end
    s_valid = 1'b0;
    n_checks++;
    if (nseen != 3 || first != 1 || last != 3)
      $display("FAIL b2b_timing: got n=%0d first=%0d last=%0d expected 3 1 3", nseen, first, last);
    else n_pass++;
    n_checks++;
    if (data_in !== 8'd30) $display("FAIL b2b_hold: got %0d expected 30", data_in);
    else n_pass++;
  endtask

  task automatic test_fifo_fill;
    int first, last, nseen;
    first = -1; last = -1; nseen = 0;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 1);
      if (s_ready) exp_samp_q.push_back(s_data);
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if (s_ready !== 1'b0 || sample_enable !== 1'b0 || exp_samp_q.size() != FIFO_DEPTH)
      $display("FAIL fill_full: got rdy=%b se=%b queued=%0d expected 0 0 %0d",
               s_ready, sample_enable, exp_samp_q.size(), FIFO_DEPTH);
    else n_pass++;
    load_start = 1'b1;
    push_coefs(NUM_TAPS);
    tick();
    load_start = 1'b0;
    for (int c = 0; c < NUM_TAPS + FIFO_DEPTH + 2; c++) begin
      if (c < NUM_TAPS) begin
        n_checks++;
        if (coef_enable !== 1'b1 || sample_enable !== 1'b0 || s_ready !== 1'b0)
          $display("FAIL fill_burst c=%0d: got ce=%b se=%b rdy=%b expected 1 0 0", c, coef_enable, sample_enable, s_ready);
        else n_pass++;
      end
      if (coef_enable === 1'b1 && exp_coef_q.size() != 0) begin
        exp_v = exp_coef_q.pop_front();
        n_checks++;
        if (data_in !== exp_v) $display("FAIL fill_coef: got %0d expected %0d", data_in, exp_v);
        else n_pass++;
      end
      if (sample_enable === 1'b1) begin
        if (first < 0) begin
          first = c;
          n_checks++;
          if (s_ready !== 1'b1) $display("FAIL fill_ready_after_pop: got %b expected 1", s_ready);
          else n_pass++;
        end
        last = c; nseen++;
        n_checks++;
        if (exp_samp_q.size() == 0) $display("FAIL fill_extra_sample: got %0d expected none", data_in);
        else begin
          exp_v = exp_samp_q.pop_front();
          if (data_in !== exp_v) $display("FAIL fill_sample: got %0d expected %0d", data_in, exp_v);
          else n_pass++;
        end
        $display("sample %0d", data_in);
      end
      tick();
    end
    n_checks++;
    if (nseen != FIFO_DEPTH || first != NUM_TAPS || last != NUM_TAPS + FIFO_DEPTH - 1 || exp_coef_q.size() != 0)
      $display("FAIL fill_timing: got n=%0d first=%0d last=%0d coefs_left=%0d expected %0d %0d %0d 0",
               nseen, first, last, exp_coef_q.size(), FIFO_DEPTH, NUM_TAPS, NUM_TAPS + FIFO_DEPTH - 1);
    else n_pass++;
  endtask

`ifndef FIR_FEEDER_RETRY_EN
  task automatic test_error;
    int bad;
    load_start = 1'b1;
    push_coefs(3);
    tick();
    load_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      exp_v = exp_coef_q.pop_front();
      if (coef_enable !== 1'b1 || data_in !== exp_v)
        $display("FAIL err_partial_burst c=%0d: got ce=%b data=%0d expected 1 %0d", c, coef_enable, data_in, exp_v);
      else n_pass++;
      fir_error = (c == 2);
      tick();
    end
    fir_error = 1'b0;
    n_checks++;
    if (coef_enable !== 1'b0 || err !== 1'b1 || loaded !== 1'b0 || busy !== 1'b0)
      $display("FAIL err_enter: got ce=%b err=%b loaded=%b busy=%b expected 0 1 0 0", coef_enable, err, loaded, busy);
    else n_pass++;
    // In ERROR: samples are accepted but held; a further fir_error is ignored.
    s_valid = 1'b1; s_data = 8'd77;
    if (s_ready) exp_samp_q.push_back(s_data);
    tick();
    s_valid = 1'b0; fir_error = 1'b1;
    tick();
    fir_error = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (coef_enable !== 1'b0 || sample_enable !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) $display("FAIL err_hold: got %0d active cycles expected 0", bad);
    else n_pass++;
    load_start = 1'b1;
    push_coefs(NUM_TAPS);
    tick();
    load_start = 1'b0;
    for (int c = 0; c < NUM_TAPS + 2; c++) begin
      n_checks++;
      if (coef_enable !== (c < NUM_TAPS) || sample_enable !== (c == NUM_TAPS))
        $display("FAIL err_reload_enables c=%0d: got ce=%b se=%b", c, coef_enable, sample_enable);
      else n_pass++;
      if (coef_enable === 1'b1 && exp_coef_q.size() != 0) begin
        exp_v = exp_coef_q.pop_front();
        n_checks++;
        if (data_in !== exp_v) $display("FAIL err_reload_coef: got %0d expected %0d", data_in, exp_v);
        else n_pass++;
      end
      if (sample_enable === 1'b1 && exp_samp_q.size() != 0) begin
        exp_v = exp_samp_q.pop_front();
        n_checks++;
        if (data_in !== exp_v) $display("FAIL err_held_sample: got %0d expected %0d", data_in, exp_v);
        else n_pass++;
        $display("sample %0d", data_in);
      end
      tick();
    end
    n_checks++;
    if (err !== 1'b1 || loaded !== 1'b1 || exp_coef_q.size() != 0 || exp_samp_q.size() != 0)
      $display("FAIL err_after_reload: got err=%b loaded=%b left=%0d/%0d expected 1 1 0/0",
               err, loaded, exp_coef_q.size(), exp_samp_q.size());
    else n_pass++;
  endtask
`else
  task automatic test_retry;
    int run, bursts;
    run = 0; bursts = 0;
    // One manual burst plus MAX_RETRY automatic ones, each cut at 3 coefficients.
    for (int b = 0; b < MAX_RETRY + 1; b++) push_coefs(3);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (coef_enable === 1'b1) begin
        run++;
        if (run == 1) bursts++;
        n_checks++;
        if (exp_coef_q.size() == 0) $display("FAIL retry_extra_coef: got %0d expected none", data_in);
        else begin
          exp_v = exp_coef_q.pop_front();
          if (data_in !== exp_v) $display("FAIL retry_coef: got %0d expected %0d", data_in, exp_v);
          else n_pass++;
        end
      end else run = 0;
      fir_error = (run == 3);
      tick();
    end
    fir_error = 1'b0;
    n_checks++;
    if (bursts != MAX_RETRY + 1 || exp_coef_q.size() != 0 || err !== 1'b1 || busy !== 1'b0 || loaded !== 1'b0)
      $display("FAIL retry_summary: got bursts=%0d left=%0d err=%b busy=%b loaded=%b expected %0d 0 1 0 0",
               bursts, exp_coef_q.size(), err, busy, loaded, MAX_RETRY + 1);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_burst;
    int bad;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    s_valid = 1'b1; s_data = 8'd55;
    tick();
    s_valid = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({coef_enable, sample_enable, busy, loaded, err, s_ready} !== 6'b0 || data_in !== '0)
      $display("FAIL midreset_outputs: got ce=%b se=%b busy=%b loaded=%b err=%b rdy=%b data=%0d, expected all 0",
               coef_enable, sample_enable, busy, loaded, err, s_ready, data_in);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || err !== 1'b0) $display("FAIL midreset_release: got rdy=%b err=%b expected 1 0", s_ready, err);
    else n_pass++;
    load_start = 1'b1;
    push_coefs(NUM_TAPS);
    tick();
    load_start = 1'b0;
    bad = 0;
    for (int c = 0; c < NUM_TAPS + 4; c++) begin
      if (coef_enable !== (c < NUM_TAPS) || sample_enable !== 1'b0) bad++;
      if (coef_enable === 1'b1 && exp_coef_q.size() != 0) begin
        exp_v = exp_coef_q.pop_front();
        n_checks++;
        if (data_in !== exp_v) $display("FAIL midreset_coef: got %0d expected %0d", data_in, exp_v);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (bad != 0 || loaded !== 1'b1 || exp_coef_q.size() != 0)
      $display("FAIL midreset_burst: got bad=%0d loaded=%b left=%0d expected 0 1 0", bad, loaded, exp_coef_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_coef_burst();
    test_back_to_back();
    test_fifo_fill();
`ifndef FIR_FEEDER_RETRY_EN
    test_error();
`else
    test_retry();
`endif
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
